// File: rtl/aer_event_sender.sv
// aer_event_sender: 4-phase AER initiator with an event FIFO, handshake timeout and sent counter.
// Define AER_ACK_SYNC_EN to pass AEROUT_ACK through a 2-flop synchroniser.
module aer_event_sender #(
    parameter int AER_WIDTH      = 12,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [AER_WIDTH-1:0]        EVT_ADDR,
    input  logic                        EVT_VALID,
    output logic                        EVT_READY,
    output logic [AER_WIDTH-1:0]        AEROUT_ADDR,
    output logic                        AEROUT_REQ,
    input  logic                        AEROUT_ACK,
    input  logic                        ERR_CLR,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT,
    output logic                        BUSY,
    output logic                        TIMEOUT_ERR,
    output logic [CNT_WIDTH-1:0]        SENT_CNT
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETUP, REQ, RELEASE} state_t;

    state_t               state;
    logic [AER_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [TW-1:0]        tmo_cnt;
    logic                 ack_i, push, pop, tmo_hit;

`ifdef AER_ACK_SYNC_EN
    logic [1:0] ack_sync;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ack_sync <= '0;
        else        ack_sync <= {ack_sync[0], AEROUT_ACK};
    end
    assign ack_i = ack_sync[1];
`else
    assign ack_i = AEROUT_ACK;
`endif

    assign EVT_READY = FIFO_COUNT != (PW+1)'(FIFO_DEPTH);
    assign push      = EVT_VALID & EVT_READY;
    assign pop       = (state == IDLE) && (FIFO_COUNT != '0);
    assign tmo_hit   = tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign BUSY      = (FIFO_COUNT != '0) || (state != IDLE);

    // storage needs no reset: the pointers alone define what is valid
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= EVT_ADDR;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_COUNT <= '0;
        end else begin
            wr_ptr     <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + PW'(1) : rd_ptr;
            FIFO_COUNT <= FIFO_COUNT + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            AEROUT_ADDR <= '0;
            AEROUT_REQ  <= 1'b0;
            tmo_cnt     <= '0;
            TIMEOUT_ERR <= 1'b0;
            SENT_CNT    <= '0;
        end else begin
            if (ERR_CLR) TIMEOUT_ERR <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        AEROUT_ADDR <= mem[rd_ptr];
                        state       <= SETUP;
                    end
                end
                // an ACK still high here is a protocol violation: hold off REQ until it drops
                SETUP: begin
                    if (!ack_i) begin
                        AEROUT_REQ <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (ack_i) begin
                        AEROUT_REQ <= 1'b0;
                        SENT_CNT   <= SENT_CNT + CNT_WIDTH'(1);
                        state      <= RELEASE;
                    end else if (tmo_hit) begin
                        AEROUT_REQ  <= 1'b0;
                        TIMEOUT_ERR <= 1'b1;
                        state       <= RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                RELEASE: begin
                    if (!ack_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aer_event_sender.sv
// tb_aer_event_sender: directed checks of the AER sender handshake, FIFO, timeout and reset.
module tb_aer_event_sender;
`ifdef AER_ACK_SYNC_EN
    localparam int AL  = 2;
    localparam int TMO = 12;
`else
    localparam int AL  = 0;
    localparam int TMO = 8;
`endif

    logic        CLK;
    logic        RST_N;
    logic [11:0] EVT_ADDR;
    logic        EVT_VALID;
    logic        EVT_READY;
    logic [11:0] AEROUT_ADDR;
    logic        AEROUT_REQ;
    logic        ack;
    logic        ERR_CLR;
    logic [4:0]  FIFO_COUNT;
    logic        BUSY;
    logic        TIMEOUT_ERR;
    logic [31:0] SENT_CNT;

    int checks = 0;
    int failures = 0;
    bit resp_en;
    int resp_dly;
    int resp_d;
    logic req_q;
    logic [11:0] addr_q;
    int unstable;
    int cur_len;
    int last_len;
    logic [11:0] rx_q[$];
    logic [11:0] exp_q[$];

    aer_event_sender #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RST_N(RST_N), .EVT_ADDR(EVT_ADDR), .EVT_VALID(EVT_VALID),
        .EVT_READY(EVT_READY), .AEROUT_ADDR(AEROUT_ADDR), .AEROUT_REQ(AEROUT_REQ),
        .AEROUT_ACK(ack), .ERR_CLR(ERR_CLR), .FIFO_COUNT(FIFO_COUNT), .BUSY(BUSY),
        .TIMEOUT_ERR(TIMEOUT_ERR), .SENT_CNT(SENT_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // core-side responder: mirrors REQ onto ACK after resp_dly cycles
    initial begin
        resp_d = 0;
        forever begin
            @(negedge CLK);
            if (resp_en) begin
                if (AEROUT_REQ != ack) begin
                    if (resp_d >= resp_dly - 1) begin
                        ack = AEROUT_REQ;
                        resp_d = 0;
                    end else resp_d++;
                end else resp_d = 0;
            end
        end
    end

    initial begin
        req_q = 1'b0; addr_q = '0; unstable = 0; cur_len = 0; last_len = 0;
        forever begin
            @(negedge CLK);
            if (AEROUT_REQ && !req_q) rx_q.push_back(AEROUT_ADDR);
            if (AEROUT_REQ && req_q && AEROUT_ADDR != addr_q) unstable++;
            if (!AEROUT_REQ && req_q) last_len = cur_len;
            cur_len = AEROUT_REQ ? cur_len + 1 : 0;
            req_q = AEROUT_REQ;
            addr_q = AEROUT_ADDR;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic push(input logic [11:0] a, output bit ok);
        int n = 0;
        EVT_ADDR = a;
        EVT_VALID = 1'b1;
        while (!EVT_READY && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        ok = EVT_READY;
        @(negedge CLK);
        EVT_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (BUSY && n < bound) begin
            @(negedge CLK);
            n++;
        end
        check(tag, BUSY, 0);
    endtask

    initial begin
        bit ok;
        int bad;
        int n;
        RST_N = 1'b0; EVT_ADDR = '0; EVT_VALID = 1'b0; ack = 1'b0; ERR_CLR = 1'b0;
        resp_en = 1'b0; resp_dly = 2;
        tick(3);
        check("rst_req", AEROUT_REQ, 0);
        check("rst_addr", AEROUT_ADDR, 0);
        check("rst_ready", EVT_READY, 1);
        check("rst_count", FIFO_COUNT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_err", TIMEOUT_ERR, 0);
        check("rst_sent", SENT_CNT, 0);
        RST_N = 1'b1;
        tick(2);

        // single handshake with a manually driven ACK
        unstable = 0;
        push(12'h00A, ok);
        check("t1_count", FIFO_COUNT, 1);
        check("t1_req_k0", AEROUT_REQ, 0);
        tick(1);
        check("t1_setup_req", AEROUT_REQ, 0);
        check("t1_setup_addr", AEROUT_ADDR, 12'h00A);
        tick(1);
        check("t1_req_k2", AEROUT_REQ, 1);
        tick(2);
        check("t1_req_held", AEROUT_REQ, 1);
        ack = 1'b1;
        tick(1 + AL);
        check("t1_req_fall", AEROUT_REQ, 0);
        check("t1_sent", SENT_CNT, 1);
        check("t1_busy_rel", BUSY, 1);
        tick(1);
        check("t1_addr_rel", AEROUT_ADDR, 12'h00A);
        ack = 1'b0;
        tick(1 + AL);
        check("t1_busy_end", BUSY, 0);
        check("t1_stable", unstable, 0);

        // fill the FIFO while the FSM is held in SETUP by a stuck ACK
        ack = 1'b1;
        tick(3);
        rx_q.delete();
        bad = 0;
        for (int i = 0; i < 17; i++) begin
            push(12'(i), ok);
            if (!ok) bad++;
        end
        check("t2_all_acc", bad, 0);
        check("t2_full_cnt", FIFO_COUNT, 16);
        check("t2_full_rdy", EVT_READY, 0);
        EVT_ADDR = 12'h011;
        EVT_VALID = 1'b1;
        tick(3);
        check("t2_refused", FIFO_COUNT, 16);
        ack = 1'b0;
        resp_en = 1'b1;
        push(12'h011, ok);
        check("t2_18th_acc", ok, 1);
        wait_idle("t2_idle", 3000);
        bad = 0;
        for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] != 12'(i)) bad++;
        check("t2_rx_n", rx_q.size(), 18);
        check("t2_order", bad, 0);
        check("t2_sent", SENT_CNT, 19);
        resp_en = 1'b0;

        // timeout with ACK tied low
        push(12'h055, ok);
        n = 0;
        for (int i = 0; i < TMO + 10; i++) begin
            @(negedge CLK);
            if (AEROUT_REQ) n++;
        end
        check("t3_req_len", n, TMO);
        check("t3_err", TIMEOUT_ERR, 1);
        check("t3_sent", SENT_CNT, 19);
        check("t3_idle", BUSY, 0);
        ERR_CLR = 1'b1;
        tick(1);
        ERR_CLR = 1'b0;
        check("t3_clr", TIMEOUT_ERR, 0);
        resp_en = 1'b1;
        push(12'h066, ok);
        wait_idle("t3_next_idle", 200);
        check("t3_next_sent", SENT_CNT, 20);
        check("t3_next_addr", rx_q[rx_q.size()-1], 12'h066);
        resp_en = 1'b0;
        push(12'h077, ok);
        tick(1 + TMO);
        check("t3_req_last", AEROUT_REQ, 1);
        ERR_CLR = 1'b1;
        tick(1);
        ERR_CLR = 1'b0;
        check("t3_req_drop", AEROUT_REQ, 0);
        check("t3_set_wins", TIMEOUT_ERR, 1);
        check("t3_sent2", SENT_CNT, 20);
        ERR_CLR = 1'b1;
        tick(1);
        ERR_CLR = 1'b0;
        check("t3_clr2", TIMEOUT_ERR, 0);
        tick(3);

        // ACK high while idle stalls the FSM in SETUP
        ack = 1'b1;
        tick(3);
        push(12'h0AB, ok);
        tick(6);
        check("t6_req_off", AEROUT_REQ, 0);
        check("t6_busy", BUSY, 1);
        check("t6_count", FIFO_COUNT, 0);
        check("t6_addr", AEROUT_ADDR, 12'h0AB);
        ack = 1'b0;
        tick(1 + AL);
        check("t6_req_on", AEROUT_REQ, 1);
        resp_en = 1'b1;
        wait_idle("t6_idle", 200);
        check("t6_sent", SENT_CNT, 21);
        check("t6_err", TIMEOUT_ERR, 0);
        resp_en = 1'b0;

        // asynchronous reset during REQ with three events queued
        for (int i = 0; i < 4; i++) push(12'h101 + 12'(i), ok);
        check("t4_req_pre", AEROUT_REQ, 1);
        check("t4_cnt_pre", FIFO_COUNT, 3);
        #2 RST_N = 1'b0;
        #1;
        check("t4_req", AEROUT_REQ, 0);
        check("t4_count", FIFO_COUNT, 0);
        check("t4_sent", SENT_CNT, 0);
        check("t4_busy", BUSY, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        n = rx_q.size();
        tick(10);
        check("t4_no_req", AEROUT_REQ, 0);
        check("t4_no_rx", rx_q.size(), n);
        check("t4_idle", BUSY, 0);

        // 100 random events against a 6-cycle responder
        rx_q.delete();
        resp_dly = 6;
        resp_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [11:0] a;
            a = 12'($urandom_range(0, 4095));
            exp_q.push_back(a);
            push(a, ok);
        end
        wait_idle("t5_idle", 10000);
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (rx_q[i] != exp_q[i]) bad++;
        check("t5_rx_n", rx_q.size(), 100);
        check("t5_order", bad, 0);
        check("t5_sent", SENT_CNT, 100);
        check("t5_req_len", last_len, 6 + AL);
        check("t5_err", TIMEOUT_ERR, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
